// File: rtl/lcd_hex_printer.sv
// lcd_hex_printer: formats a 16-bit result as uppercase hex ASCII
// and feeds it character by character into the LCD controller handshake.
module lcd_hex_printer #(
    parameter bit         SIGNED_MODE = 1'b1,
    parameter bit         SEP_EN      = 1'b1,
    parameter logic [7:0] SEP_CHAR    = 8'h20
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] iValue,
    input  logic        iStart,
    input  logic        iLCD_Ready,
    output logic        oLCD_Write,
    output logic [7:0]  oLCD_Data,
    output logic        oBusy,
    output logic        oDone
);

    typedef enum logic [2:0] {
        IDLE,
        SIGN,
        DIGIT,
        SEP,
        WAIT_ACK,
        WAIT_RDY,
        FINISH
    } state_t;

    state_t      state_q, state_d;
    state_t      next_q, next_d;
    logic [15:0] value_q, value_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  nib;
    logic [7:0]  char;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            next_q  <= IDLE;
            value_q <= 16'h0000;
            cnt_q   <= 2'd0;
            write_q <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            next_q  <= next_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // FINISH is already idle from the outside, so it accepts a new start too
    always_comb begin
        state_d = state_q;
        next_d  = next_q;
        value_d = value_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, FINISH: begin
                if (iStart) begin
                    cnt_d = 2'd3;
                    if (SIGNED_MODE && iValue[15]) begin
                        value_d = ~iValue + 16'd1;
                        state_d = SIGN;
                    end else begin
                        value_d = iValue;
                        state_d = DIGIT;
                    end
                end else if (state_q == FINISH) begin
                    state_d = IDLE;
                end
            end
            SIGN: begin
                if (iLCD_Ready) begin
                    next_d  = DIGIT;
                    state_d = WAIT_ACK;
                end
            end
            DIGIT: begin
                if (iLCD_Ready) begin
                    if (cnt_q == 2'd0) begin
                        next_d = SEP_EN ? SEP : FINISH;
                    end else begin
                        next_d = DIGIT;
                        cnt_d  = cnt_q - 2'd1;
                    end
                    state_d = WAIT_ACK;
                end
            end
            SEP: begin
                if (iLCD_Ready) begin
                    next_d  = FINISH;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!iLCD_Ready) state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (iLCD_Ready) state_d = next_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nib = value_q[{cnt_q, 2'b00} +: 4];
        if (nib < 4'd10) char = 8'h30 + {4'h0, nib};
        else             char = 8'h37 + {4'h0, nib};
        if (state_q == SIGN) char = 8'h2D;
        if (state_q == SEP)  char = SEP_CHAR;

        write_d = (state_d == WAIT_ACK) && (state_q != WAIT_ACK);
        data_d  = write_d ? char : data_q;
        busy_d  = !(state_d inside {IDLE, FINISH});
        done_d  = (state_d == FINISH) && (state_q == WAIT_RDY);
    end

    assign oLCD_Write = write_q;
    assign oLCD_Data  = data_q;
    assign oBusy      = busy_q;
    assign oDone      = done_q;

endmodule
